// File: rtl/onehot_index_capture_if.sv
// onehot_index_capture_if: handshake bundle between the 6-to-64 decoder side
// (in_*) and the downstream consumer (out_*). The master modport is the
// environment driving words in and consuming results; the slave modport is
// the capture stage itself.
interface onehot_index_capture_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic [5:0]  out_idx;
  logic [1:0]  out_stat;
  logic        out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_idx,
    input  out_stat
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_idx,
    output out_stat
  );
endinterface

// File: rtl/onehot_index_capture.sv
// onehot_index_capture: registered one-hot-to-index stage placed after the
// 6-to-64 line decoder. Each accepted 64-bit select word is checked for
// exactly one set line, encoded to a 6-bit index with a 2-bit status, and
// held in a one-entry output register. Non-OK words are counted in a
// saturating 8-bit counter and latch a sticky error flag.
//
// Optional feature: define ONEHOT_CAPTURE_HIST_EN to keep a 64-bit history
// of indices accepted OK and drive o_all_seen once every index was seen.
// Without the macro o_all_seen is tied low.
module onehot_index_capture (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clr,
  onehot_index_capture_if.slave   s_if,
  output logic                    o_err,
  output logic [7:0]              o_err_cnt,
  output logic                    o_all_seen
);

  localparam int N = 64;
  localparam int W = 6;

  localparam logic [1:0] STAT_OK    = 2'b00;
  localparam logic [1:0] STAT_ZERO  = 2'b01;
  localparam logic [1:0] STAT_MULTI = 2'b10;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Number of set lines in a select word.
  function automatic logic [W:0] f_popcount(input logic [N-1:0] word);
    logic [W:0] cnt;
    cnt = {(W+1){1'b0}};
    for (int i = 0; i < N; i++) begin
      cnt = cnt + {{W{1'b0}}, word[i]};
    end
    return cnt;
  endfunction

  // Index of the lowest set line; 0 when no line is set.
  function automatic logic [W-1:0] f_lowest_index(input logic [N-1:0] word);
    logic [W-1:0] idx;
    idx = {W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (word[i]) begin
        idx = i[W-1:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_t         r_state;
  logic           r_out_valid;
  logic [W-1:0]   r_out_idx;
  logic [1:0]     r_out_stat;
  logic           r_err;
  logic [7:0]     r_err_cnt;

  logic [W:0]     w_pop;
  logic [W-1:0]   w_enc_idx;
  logic [1:0]     w_enc_stat;
  logic           w_accept;
  logic           w_bad_accept;

  // Classify the incoming word and pick the index reported for it.
  always_comb begin
    w_pop      = f_popcount(s_if.in_data);
    w_enc_idx  = {W{1'b0}};
    w_enc_stat = STAT_OK;
    if (w_pop == 7'd1) begin
      w_enc_idx  = f_lowest_index(s_if.in_data);
      w_enc_stat = STAT_OK;
    end else if (w_pop == 7'd0) begin
      w_enc_idx  = {W{1'b0}};
      w_enc_stat = STAT_ZERO;
    end else begin
      w_enc_idx  = f_lowest_index(s_if.in_data);
      w_enc_stat = STAT_MULTI;
    end
  end

  // Ready whenever the slot is free or is being drained this cycle.
  assign s_if.in_ready = !r_out_valid || s_if.out_ready;
  assign w_accept      = s_if.in_valid && s_if.in_ready;
  assign w_bad_accept  = w_accept && (w_enc_stat != STAT_OK);

  // Output slot state machine: load on accept, drain on out_ready.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_out_idx   <= {W{1'b0}};
      r_out_stat  <= STAT_OK;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
            r_out_idx   <= w_enc_idx;
            r_out_stat  <= w_enc_stat;
          end else begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (w_accept) begin
            // Drain and refill in the same cycle: stay full with new word.
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
            r_out_idx   <= w_enc_idx;
            r_out_stat  <= w_enc_stat;
          end else if (s_if.out_ready) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end else begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Error accounting; a same-cycle clear never hides a new error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else if (w_bad_accept) begin
      r_err <= 1'b1;
      if (i_clr) begin
        r_err_cnt <= 8'd1;
      end else if (r_err_cnt == 8'd255) begin
        r_err_cnt <= 8'd255;
      end else begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end else if (i_clr) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_err     <= r_err;
      r_err_cnt <= r_err_cnt;
    end
  end

`ifdef ONEHOT_CAPTURE_HIST_EN
  logic [N-1:0] r_hist;
  logic [N-1:0] w_hist_next;
  logic [N-1:0] w_hist_bit;
  logic         r_all_seen;

  // Next history: clear first (if requested), then add an OK capture.
  always_comb begin
    w_hist_bit  = {{(N-1){1'b0}}, 1'b1} << w_enc_idx;
    w_hist_next = r_hist;
    if (w_accept && (w_enc_stat == STAT_OK)) begin
      if (i_clr) begin
        w_hist_next = w_hist_bit;
      end else begin
        w_hist_next = r_hist | w_hist_bit;
      end
    end else if (i_clr) begin
      w_hist_next = {N{1'b0}};
    end else begin
      w_hist_next = r_hist;
    end
  end

  // History register and its registered all-ones summary.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hist     <= {N{1'b0}};
      r_all_seen <= 1'b0;
    end else begin
      r_hist     <= w_hist_next;
      r_all_seen <= &w_hist_next;
    end
  end

  assign o_all_seen = r_all_seen;
`else
  assign o_all_seen = 1'b0;
`endif

  assign s_if.out_valid = r_out_valid;
  assign s_if.out_idx   = r_out_idx;
  assign s_if.out_stat  = r_out_stat;
  assign o_err          = r_err;
  assign o_err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_onehot_index_capture.sv
// tb_onehot_index_capture: directed bench for onehot_index_capture. Inputs
// change 1 time unit after each rising edge; outputs are compared there too,
// well away from the next active edge.
module tb_onehot_index_capture;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       err;
  logic [7:0] err_cnt;
  logic       all_seen;

  int n_checks;
  int n_errors;

  onehot_index_capture_if bus ();

  onehot_index_capture u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clr      (clr),
    .s_if       (bus.slave),
    .o_err      (err),
    .o_err_cnt  (err_cnt),
    .o_all_seen (all_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ONEHOT_CAPTURE_HIST_EN
  localparam logic EXP_ALL_SEEN = 1'b1;
`else
  localparam logic EXP_ALL_SEEN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 64'd0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out",       {58'd0, bus.out_idx},   64'd0);
    chk("rst_stat",      {62'd0, bus.out_stat},  64'd0);
    chk("rst_err",       {63'd0, err},           64'd0);
    chk("rst_err_cnt",   {56'd0, err_cnt},       64'd0);
    chk("rst_all_seen",  {63'd0, all_seen},      64'd0);
    chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);

    // Full sweep of every single-line word at one word per cycle
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.in_data = 64'd1 << i;
      tick();
      chk("sweep_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("sweep_out",   {58'd0, bus.out_idx},   64'(i));
      chk("sweep_stat",  {62'd0, bus.out_stat},  64'd0);
      if (i == 62) begin
        chk("sweep_all_seen_62", {63'd0, all_seen}, 64'd0);
      end
    end
    chk("sweep_err_cnt",  {56'd0, err_cnt},  64'd0);
    chk("sweep_all_seen", {63'd0, all_seen}, {63'd0, EXP_ALL_SEEN});

    // Invalid words: none set, then two set (bits 4 and 7)
    bus.in_data = 64'd0;
    tick();
    chk("zero_out",  {58'd0, bus.out_idx},  64'd0);
    chk("zero_stat", {62'd0, bus.out_stat}, 64'd1);
    bus.in_data = 64'h0000_0000_0000_0090;
    tick();
    chk("multi_out",     {58'd0, bus.out_idx},  64'd4);
    chk("multi_stat",    {62'd0, bus.out_stat}, 64'd2);
    chk("multi_err_cnt", {56'd0, err_cnt},      64'd2);
    chk("multi_err",     {63'd0, err},          64'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("drain_valid", {63'd0, bus.out_valid}, 64'd0);

`ifdef ONEHOT_CAPTURE_HIST_EN
    // Clear drops the history summary
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_all_seen", {63'd0, all_seen}, 64'd0);
    chk("clr_err_cnt",  {56'd0, err_cnt},  64'd0);
`endif

    // Backpressure: word 9 held while word 10 is offered
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'd1 << 9;
    tick();
    chk("bp_first_out", {58'd0, bus.out_idx}, 64'd9);
    bus.in_data = 64'd1 << 10;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      tick();
      chk("bp_hold_out",   {58'd0, bus.out_idx},   64'd9);
      chk("bp_hold_valid", {63'd0, bus.out_valid}, 64'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {63'd0, bus.in_ready}, 64'd1);
    tick();
    chk("bp_new_out", {58'd0, bus.out_idx}, 64'd10);
    bus.in_valid = 1'b0;
    tick();

    // Saturation: 300 zero words, clear with and without a new error
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 64'd0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 100) begin
        chk("sat_cnt_100", {56'd0, err_cnt}, 64'd100);
      end
      if (k == 256) begin
        chk("sat_cnt_256", {56'd0, err_cnt}, 64'd255);
      end
    end
    chk("sat_cnt_300", {56'd0, err_cnt}, 64'd255);
    clr = 1'b1;
    tick();
    chk("clr_err_cnt_1", {56'd0, err_cnt}, 64'd1);
    chk("clr_err_1",     {63'd0, err},     64'd1);
    bus.in_valid = 1'b0;
    tick();
    clr = 1'b0;
    chk("clr_err_cnt_0", {56'd0, err_cnt}, 64'd0);
    chk("clr_err_0",     {63'd0, err},     64'd0);

    // Mid-operation reset while full, stalled and with err_cnt=5
    bus.in_valid = 1'b1;
    bus.in_data  = 64'd0;
    for (int k = 0; k < 5; k++) begin
      tick();
    end
    bus.out_ready = 1'b0;
    bus.in_data   = 64'd1 << 3;
    tick();
    chk("mr_pre_cnt",   {56'd0, err_cnt},       64'd5);
    chk("mr_pre_valid", {63'd0, bus.out_valid}, 64'd1);
    rst = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("mr_valid",    {63'd0, bus.out_valid}, 64'd0);
    chk("mr_out",      {58'd0, bus.out_idx},   64'd0);
    chk("mr_err_cnt",  {56'd0, err_cnt},       64'd0);
    chk("mr_err",      {63'd0, err},           64'd0);
    chk("mr_all_seen", {63'd0, all_seen},      64'd0);
    chk("mr_in_ready", {63'd0, bus.in_ready},  64'd1);

    // Reset beats a same-cycle accept
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'd1 << 7;
    rst           = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_acc_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_acc_out",   {58'd0, bus.out_idx},   64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
